cis_pattern_sequencer: RTL and testbench
========================================

CIS_PATTERN_SEQUENCER -- requirements
Module: cis_pattern_sequencer

Interface
REQ-001 SHALL have parameter NUM_SIGNALS, default 9: number of pattern-driven output lines.
REQ-002 SHALL have parameter PATTERN_LEN, default 16: maximum steps per phase pattern.
REQ-003 SHALL have parameter CNT_W, default 14: skip-sample counter width.
REQ-004 SHALL have parameter PIX_W, default 5: pixel-in-cluster counter width.
REQ-005 SHALL have parameter DIV_W, default 10: clock divider width; LEN_W = clog2(PATTERN_LEN+1).
REQ-006 SHALL have clk  in  1: clock.
REQ-007 SHALL have reset  in  1: reset, asynchronous, active-high.
REQ-008 SHALL have clk_div  in  DIV_W: tick period minus one.
REQ-009 SHALL have integration  in  1: high = photodiode integrating; rising level starts a frame.
REQ-010 SHALL have global_shutter  in  1: repeat skipping across cluster pixels.
REQ-011 SHALL have abort  in  1: synchronous frame abort.
REQ-012 SHALL have skip_samples  in  CNT_W: skip-pattern repetitions per pixel.
REQ-013 SHALL have num_pixels  in  PIX_W: pixels per cluster in global-shutter mode.
REQ-014 SHALL have len_reset, len_integ, len_skip  in  LEN_W each: active steps per phase.
REQ-015 SHALL have pattern_reset, pattern_integ, pattern_skip  in  [NUM_SIGNALS][PATTERN_LEN] each: per-signal step bits.
REQ-016 SHALL have sig_out  out  NUM_SIGNALS: current pattern column.
REQ-017 SHALL have row_rst, row_clk  out  1 each: pixel-select logic controls.
REQ-018 SHALL have busy, frame_done  out  1 each: status; frame_done is a one-clk pulse.
REQ-019 SHALL have sample_cnt  out  CNT_W and pixel_cnt  out  PIX_W: current skip sample and pixel indices.

Function
REQ-020 Divider SHALL count 0..clk_div; tick is high in the cycle count==clk_div, then count wraps to 0; clk_div=0 gives a tick every clk.
REQ-021 FSM states SHALL be IDLE, RESET_PH, INTEG_PH, SKIP_PH; all transitions, step advances and counter updates (except abort) occur only on tick.
REQ-022 At step k of a phase, sig_out[s] SHALL equal that phase's pattern[s][k] (LSB first); in IDLE sig_out = 0.
REQ-023 IDLE + tick + integration=1 SHALL latch skip_samples, num_pixels, global_shutter, len_*, and enter RESET_PH at step 0; latched values apply for the whole frame.
REQ-024 Latched zero values of len_*, skip_samples or num_pixels SHALL be treated as 1; len_* > PATTERN_LEN SHALL be clamped to PATTERN_LEN.
REQ-025 Patterns SHALL NOT be latched; they must stay static while busy=1.
REQ-026 RESET_PH SHALL advance one step per tick; the tick at the last step enters INTEG_PH step 0.
REQ-027 INTEG_PH SHALL hold step 0 while integration=1; once low, advance per tick; the tick at the last step enters SKIP_PH step 0 with sample_cnt=0, pixel_cnt=0.
REQ-028 SKIP_PH, tick at last step: if sample_cnt+1 < skips, sample_cnt increments and the pattern restarts at step 0.
REQ-029 Otherwise, if global_shutter and pixel_cnt+1 < num_pixels: pixel_cnt increments, sample_cnt=0, row_clk asserts, and the pattern restarts.
REQ-030 Otherwise row_clk asserts, frame_done pulses one clk, and the FSM returns to IDLE.
REQ-031 row_clk SHALL stay high until the next tick, then return low.
REQ-032 busy SHALL be high whenever state != IDLE.
REQ-033 abort=1 in any cycle SHALL, next clk: set state IDLE, sig_out 0, clear counters, assert row_rst until the next tick; no frame_done.
REQ-034 integration changes outside IDLE/INTEG_PH SHALL be ignored; a new frame starts only from IDLE.

Reset
REQ-035 While reset is high: state IDLE, sig_out=0, busy=0, frame_done=0, row_clk=0, counters=0, divider=0, row_rst=1.
REQ-036 row_rst SHALL remain 1 after reset release until the first tick, then go 0.

Verification
REQ-037 clk_div=0, len_*=4, skip_samples=3, gs=0, integration pulse then low -> 4 reset + 4 integ + 12 skip steps, one row_clk, frame_done after the last step.
REQ-038 clk_div=3 -> every sig_out change and FSM step lands exactly 4 clk apart.
REQ-039 gs=1, num_pixels=3, skip_samples=2 -> 6 skip patterns, row_clk 3 times, pixel_cnt 0,1,2, one frame_done.
REQ-040 len_skip=0, skip_samples=0 -> one skip step with pattern_skip[*][0] driven, then IDLE.
REQ-041 abort mid-SKIP_PH -> next clk busy=0, sig_out=0, row_rst=1 until the next tick, no frame_done.
REQ-042 reset asserted mid-frame -> all outputs at reset values immediately; row_rst held until the first post-release tick.

Source files
------------

// File: rtl/cis_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module : cis_pattern_sequencer
// Brief  : Steps reset / integrate / skip-sample pattern tables onto the
//          sensor control lines, repeating skip samples per cluster pixel.
// Rev    : 1.0 - initial release
// ============================================================================
module cis_pattern_sequencer #(
    parameter int NUM_SIGNALS = 9,
    parameter int PATTERN_LEN = 16,
    parameter int CNT_W       = 14,
    parameter int PIX_W       = 5,
    parameter int DIV_W       = 10,
    localparam int LEN_W      = $clog2(PATTERN_LEN + 1)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [DIV_W-1:0]                        clk_div,
    input  logic                                    integration,
    input  logic                                    global_shutter,
    input  logic                                    abort,
    input  logic [CNT_W-1:0]                        skip_samples,
    input  logic [PIX_W-1:0]                        num_pixels,
    input  logic [LEN_W-1:0]                        len_reset,
    input  logic [LEN_W-1:0]                        len_integ,
    input  logic [LEN_W-1:0]                        len_skip,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_reset,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_integ,
    input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_skip,
    output logic [NUM_SIGNALS-1:0]                  sig_out,
    output logic                                    row_rst,
    output logic                                    row_clk,
    output logic                                    busy,
    output logic                                    frame_done,
    output logic [CNT_W-1:0]                        sample_cnt,
    output logic [PIX_W-1:0]                        pixel_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESET_PH = 2'd1,
        INTEG_PH = 2'd2,
        SKIP_PH  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_step, w_step_nxt;
    logic [CNT_W-1:0]   r_sample, w_sample_nxt;
    logic [PIX_W-1:0]   r_pixel, w_pixel_nxt;
    logic [LEN_W-1:0]   r_len_reset, w_len_reset_nxt;
    logic [LEN_W-1:0]   r_len_integ, w_len_integ_nxt;
    logic [LEN_W-1:0]   r_len_skip, w_len_skip_nxt;
    logic [CNT_W-1:0]   r_skips, w_skips_nxt;
    logic [PIX_W-1:0]   r_npix, w_npix_nxt;
    logic               r_gs, w_gs_nxt;
    logic               r_row_clk, w_row_clk_nxt;
    logic               r_row_rst, w_row_rst_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic [DIV_W-1:0]   r_div;
    logic               w_tick;
    logic [LEN_W-1:0]   w_len_cur;
    logic               w_last;
    logic               w_more_samples;
    logic               w_more_pixels;
    logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] w_pat;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0)
            return LEN_W'(1);
        else if (len > LEN_W'(PATTERN_LEN))
            return LEN_W'(PATTERN_LEN);
        else
            return len;
    endfunction

    // >= rather than == so that lowering clk_div mid-count never waits for a full wrap
    assign w_tick = (r_div >= clk_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + DIV_W'(1);
    end

    always_comb begin
        w_len_cur = r_len_reset;
        w_pat     = pattern_reset;
        case (r_state)
            INTEG_PH: begin
                w_len_cur = r_len_integ;
                w_pat     = pattern_integ;
            end
            SKIP_PH: begin
                w_len_cur = r_len_skip;
                w_pat     = pattern_skip;
            end
            default: ;
        endcase
    end

    assign w_last         = (r_step == w_len_cur - LEN_W'(1));
    assign w_more_samples = ((CNT_W+1)'(r_sample) + (CNT_W+1)'(1)) < (CNT_W+1)'(r_skips);
    assign w_more_pixels  = r_gs && (((PIX_W+1)'(r_pixel) + (PIX_W+1)'(1)) < (PIX_W+1)'(r_npix));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_step       <= '0;
            r_sample     <= '0;
            r_pixel      <= '0;
            r_len_reset  <= '0;
            r_len_integ  <= '0;
            r_len_skip   <= '0;
            r_skips      <= '0;
            r_npix       <= '0;
            r_gs         <= 1'b0;
            r_row_clk    <= 1'b0;
            r_row_rst    <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            r_sample     <= w_sample_nxt;
            r_pixel      <= w_pixel_nxt;
            r_len_reset  <= w_len_reset_nxt;
            r_len_integ  <= w_len_integ_nxt;
            r_len_skip   <= w_len_skip_nxt;
            r_skips      <= w_skips_nxt;
            r_npix       <= w_npix_nxt;
            r_gs         <= w_gs_nxt;
            r_row_clk    <= w_row_clk_nxt;
            r_row_rst    <= w_row_rst_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_step_nxt       = r_step;
        w_sample_nxt     = r_sample;
        w_pixel_nxt      = r_pixel;
        w_len_reset_nxt  = r_len_reset;
        w_len_integ_nxt  = r_len_integ;
        w_len_skip_nxt   = r_len_skip;
        w_skips_nxt      = r_skips;
        w_npix_nxt       = r_npix;
        w_gs_nxt         = r_gs;
        w_row_clk_nxt    = r_row_clk;
        w_row_rst_nxt    = r_row_rst;
        w_frame_done_nxt = 1'b0;

        if (abort) begin
            w_state_nxt   = IDLE;
            w_step_nxt    = '0;
            w_sample_nxt  = '0;
            w_pixel_nxt   = '0;
            w_row_clk_nxt = 1'b0;
            w_row_rst_nxt = 1'b1;
        end else if (w_tick) begin
            w_row_rst_nxt = 1'b0;
            w_row_clk_nxt = 1'b0;
            case (r_state)
                IDLE: begin
                    if (integration) begin
                        w_len_reset_nxt = clamp_len(len_reset);
                        w_len_integ_nxt = clamp_len(len_integ);
                        w_len_skip_nxt  = clamp_len(len_skip);
                        w_skips_nxt     = (skip_samples == '0) ? CNT_W'(1) : skip_samples;
                        w_npix_nxt      = (num_pixels == '0) ? PIX_W'(1) : num_pixels;
                        w_gs_nxt        = global_shutter;
                        w_state_nxt     = RESET_PH;
                        w_step_nxt      = '0;
                    end
                end
                RESET_PH: begin
                    w_step_nxt = w_last ? '0 : r_step + LEN_W'(1);
                    if (w_last)
                        w_state_nxt = INTEG_PH;
                end
                INTEG_PH: begin
                    if (!integration) begin
                        w_step_nxt = w_last ? '0 : r_step + LEN_W'(1);
                        if (w_last) begin
                            w_state_nxt  = SKIP_PH;
                            w_sample_nxt = '0;
                            w_pixel_nxt  = '0;
                        end
                    end
                end
                SKIP_PH: begin
                    if (!w_last) begin
                        w_step_nxt = r_step + LEN_W'(1);
                    end else if (w_more_samples) begin
                        w_step_nxt   = '0;
                        w_sample_nxt = r_sample + CNT_W'(1);
                    end else if (w_more_pixels) begin
                        w_step_nxt    = '0;
                        w_sample_nxt  = '0;
                        w_pixel_nxt   = r_pixel + PIX_W'(1);
                        w_row_clk_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = IDLE;
                        w_step_nxt       = '0;
                        w_sample_nxt     = '0;
                        w_pixel_nxt      = '0;
                        w_row_clk_nxt    = 1'b1;
                        w_frame_done_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Pattern column is muxed live: tables are required to stay static while busy
    always_comb begin
        sig_out = '0;
        if (r_state != IDLE) begin
            for (int s = 0; s < NUM_SIGNALS; s++) begin
                for (int k = 0; k < PATTERN_LEN; k++) begin
                    if (r_step == LEN_W'(k))
                        sig_out[s] = w_pat[s][k];
                end
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign row_rst    = r_row_rst;
    assign row_clk    = r_row_clk;
    assign frame_done = r_frame_done;
    assign sample_cnt = r_sample;
    assign pixel_cnt  = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_cis_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_cis_pattern_sequencer
// Brief  : Directed scoreboard bench for cis_pattern_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cis_pattern_sequencer;

    localparam int NS = 9;
    localparam int PL = 16;
    localparam int CW = 14;
    localparam int PW = 5;
    localparam int DW = 10;
    localparam int LW = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DW-1:0]          clk_div;
    logic                   integration;
    logic                   global_shutter;
    logic                   abort;
    logic [CW-1:0]          skip_samples;
    logic [PW-1:0]          num_pixels;
    logic [LW-1:0]          len_reset, len_integ, len_skip;
    logic [NS-1:0][PL-1:0]  pattern_reset, pattern_integ, pattern_skip;
    logic [NS-1:0]          sig_out;
    logic                   row_rst, row_clk, busy, frame_done;
    logic [CW-1:0]          sample_cnt;
    logic [PW-1:0]          pixel_cnt;

    cis_pattern_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .clk_div        (clk_div),
        .integration    (integration),
        .global_shutter (global_shutter),
        .abort          (abort),
        .skip_samples   (skip_samples),
        .num_pixels     (num_pixels),
        .len_reset      (len_reset),
        .len_integ      (len_integ),
        .len_skip       (len_skip),
        .pattern_reset  (pattern_reset),
        .pattern_integ  (pattern_integ),
        .pattern_skip   (pattern_skip),
        .sig_out        (sig_out),
        .row_rst        (row_rst),
        .row_clk        (row_clk),
        .busy           (busy),
        .frame_done     (frame_done),
        .sample_cnt     (sample_cnt),
        .pixel_cnt      (pixel_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          busy;
        logic [NS-1:0] sig;
        logic [CW-1:0] smp;
        logic [PW-1:0] pix;
        logic          rr;
        logic          rcr;
        logic          done;
        int            gap;
    } ev_t;

    ev_t expq[$];
    int  nchk  = 0;
    int  npass = 0;

    // Column code: phase id in [8:7], step index in [3:0]; never zero while busy
    function automatic logic [NS-1:0] col(input int ph, input int k);
        logic [NS-1:0] c;
        c      = '0;
        c[8:7] = ph[1:0];
        c[3:0] = k[3:0];
        return c;
    endfunction

    task automatic push_ev(input logic b, input logic [NS-1:0] s, input int smp, input int pix,
                           input logic rr, input logic rcr, input logic dn, input int gap);
        ev_t e;
        e.busy = b;  e.sig = s;  e.smp = CW'(smp);  e.pix = PW'(pix);
        e.rr = rr;   e.rcr = rcr; e.done = dn;      e.gap = gap;
        expq.push_back(e);
    endtask

    task automatic push_step(input int ph, input int k, input int smp, input int pix,
                             input logic rcr, input int gap);
        push_ev(1'b1, col(ph, k), smp, pix, 1'b0, rcr, 1'b0, gap);
    endtask

    task automatic push_idle(input logic rr, input logic rcr, input logic dn, input int gap);
        push_ev(1'b0, '0, 0, 0, rr, rcr, dn, gap);
    endtask

    // Monitor: an event is any change of the observed tuple, a row_clk rise or frame_done
    logic          mon_en = 1'b0;
    logic          p_valid = 1'b0;
    logic          p_busy, p_rr, p_rc;
    logic [NS-1:0] p_sig;
    logic [CW-1:0] p_smp;
    logic [PW-1:0] p_pix;
    logic          m_rcr, m_chg, m_ok;
    int            m_gap;
    int            cyc = 0;
    int            last_cyc = 0;
    int            n_ev = 0;
    ev_t           m_exp;

    always @(negedge clk) begin
        if (mon_en) begin
            m_rcr = row_clk && p_valid && !p_rc;
            m_chg = !p_valid || (busy !== p_busy) || (sig_out !== p_sig) || (sample_cnt !== p_smp) ||
                    (pixel_cnt !== p_pix) || (row_rst !== p_rr) || m_rcr || (frame_done !== 1'b0);
            if (m_chg) begin
                m_gap = cyc - last_cyc;
                last_cyc = cyc;
                nchk++;
                if (expq.size() == 0) begin
                    $display("FAIL ev%0d unexpected: busy=%0b sig=%h smp=%0d pix=%0d rr=%0b rc_rise=%0b done=%0b, required no event",
                             n_ev, busy, sig_out, sample_cnt, pixel_cnt, row_rst, m_rcr, frame_done);
                end else begin
                    m_exp = expq.pop_front();
                    m_ok = (busy === m_exp.busy) && (sig_out === m_exp.sig) && (sample_cnt === m_exp.smp) &&
                           (pixel_cnt === m_exp.pix) && (row_rst === m_exp.rr) && (m_rcr === m_exp.rcr) &&
                           (frame_done === m_exp.done) && (m_exp.gap == 0 || m_gap == m_exp.gap);
                    if (m_ok)
                        npass++;
                    else
                        $display("FAIL ev%0d: got busy=%0b sig=%h smp=%0d pix=%0d rr=%0b rc_rise=%0b done=%0b gap=%0d; required busy=%0b sig=%h smp=%0d pix=%0d rr=%0b rc_rise=%0b done=%0b gap=%0d",
                                 n_ev, busy, sig_out, sample_cnt, pixel_cnt, row_rst, m_rcr, frame_done, m_gap,
                                 m_exp.busy, m_exp.sig, m_exp.smp, m_exp.pix, m_exp.rr, m_exp.rcr, m_exp.done, m_exp.gap);
                end
                n_ev++;
            end
            p_valid = 1'b1;
            p_busy  = busy;
            p_sig   = sig_out;
            p_smp   = sample_cnt;
            p_pix   = pixel_cnt;
            p_rr    = row_rst;
            p_rc    = row_clk;
            cyc++;
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            nchk++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic wait_sig(input logic [NS-1:0] v, input int budget);
        int n = 0;
        while (sig_out !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sig_out !== v) begin
            nchk++;
            $display("FAIL wait_sig: sig_out=%h after %0d cycles, required %h", sig_out, budget, v);
        end
    endtask

    task automatic wait_smp(input int v, input int budget);
        int n = 0;
        while (sample_cnt !== CW'(v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sample_cnt !== CW'(v)) begin
            nchk++;
            $display("FAIL wait_smp: sample_cnt=%0d after %0d cycles, required %0d", sample_cnt, budget, v);
        end
    endtask

    task automatic set_frame(input int lr, input int li, input int ls, input int sk,
                             input int np, input logic gs);
        len_reset      = LW'(lr);
        len_integ      = LW'(li);
        len_skip       = LW'(ls);
        skip_samples   = CW'(sk);
        num_pixels     = PW'(np);
        global_shutter = gs;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NS-1:0] c;
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < PL; k++) begin
                c = col(1, k); pattern_reset[s][k] = c[s];
                c = col(2, k); pattern_integ[s][k] = c[s];
                c = col(3, k); pattern_skip[s][k]  = c[s];
            end
        end
        reset = 1'b1;
        clk_div = '0;
        integration = 1'b0;
        abort = 1'b0;
        set_frame(4, 4, 4, 3, 1, 1'b0);

        // Reset values, then row_rst drops on the first tick after release
        push_idle(1'b1, 1'b0, 1'b0, 0);
        push_idle(1'b0, 1'b0, 1'b0, 0);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 4 reset + 4 integ + 3x4 skip steps, one row_clk, frame_done
        for (int k = 0; k < 4; k++) push_step(1, k, 0, 0, 1'b0, (k == 0) ? 0 : 1);
        for (int k = 0; k < 4; k++) push_step(2, k, 0, 0, 1'b0, (k == 1) ? 0 : 1);
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 4; k++) push_step(3, k, s, 0, 1'b0, 1);
        push_idle(1'b0, 1'b1, 1'b1, 1);
        set_frame(4, 4, 4, 3, 1, 1'b0);
        integration = 1'b1;
        repeat (8) @(negedge clk);
        integration = 1'b0;
        wait_idle(200);
        repeat (3) @(negedge clk);

        // clk_div=3: every step four clocks apart
        push_step(1, 0, 0, 0, 1'b0, 0);
        push_step(1, 1, 0, 0, 1'b0, 4);
        push_step(2, 0, 0, 0, 1'b0, 4);
        push_step(3, 0, 0, 0, 1'b0, 0);
        push_step(3, 1, 0, 0, 1'b0, 4);
        push_idle(1'b0, 1'b1, 1'b1, 4);
        clk_div = DW'(3);
        set_frame(2, 1, 2, 1, 1, 1'b0);
        integration = 1'b1;
        repeat (14) @(negedge clk);
        integration = 1'b0;
        wait_idle(200);
        repeat (6) @(negedge clk);
        clk_div = '0;
        repeat (2) @(negedge clk);

        // Global shutter: 3 pixels x 2 samples, row_clk per pixel advance and at the end
        push_step(1, 0, 0, 0, 1'b0, 0);
        push_step(2, 0, 0, 0, 1'b0, 1);
        push_step(3, 0, 0, 0, 1'b0, 0);
        push_step(3, 0, 1, 0, 1'b0, 1);
        push_step(3, 0, 0, 1, 1'b1, 1);
        push_step(3, 0, 1, 1, 1'b0, 1);
        push_step(3, 0, 0, 2, 1'b1, 1);
        push_step(3, 0, 1, 2, 1'b0, 1);
        push_idle(1'b0, 1'b1, 1'b1, 1);
        set_frame(1, 1, 1, 2, 3, 1'b1);
        integration = 1'b1;
        repeat (3) @(negedge clk);
        integration = 1'b0;
        wait_idle(200);
        repeat (3) @(negedge clk);

        // Zero lengths/counts act as 1; oversize reset length clamps to 16 steps
        for (int k = 0; k < 16; k++) push_step(1, k, 0, 0, 1'b0, (k == 0) ? 0 : 1);
        push_step(2, 0, 0, 0, 1'b0, 1);
        push_step(3, 0, 0, 0, 1'b0, 1);
        push_idle(1'b0, 1'b1, 1'b1, 1);
        set_frame(20, 0, 0, 0, 0, 1'b1);
        integration = 1'b1;
        @(negedge clk);
        integration = 1'b0;
        wait_idle(200);
        repeat (3) @(negedge clk);

        // Abort during skip phase: idle next clk, row_rst until the next tick, no frame_done
        push_step(1, 0, 0, 0, 1'b0, 0);
        push_step(1, 1, 0, 0, 1'b0, 1);
        push_step(2, 0, 0, 0, 1'b0, 1);
        push_step(2, 1, 0, 0, 1'b0, 0);
        push_step(3, 0, 0, 0, 1'b0, 1);
        push_step(3, 1, 0, 0, 1'b0, 1);
        push_step(3, 0, 1, 0, 1'b0, 1);
        push_idle(1'b1, 1'b0, 1'b0, 1);
        push_idle(1'b0, 1'b0, 1'b0, 1);
        set_frame(2, 2, 2, 4, 1, 1'b0);
        integration = 1'b1;
        repeat (4) @(negedge clk);
        integration = 1'b0;
        wait_smp(1, 50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-frame; row_rst held to the first tick after release
        push_step(1, 0, 0, 0, 1'b0, 0);
        push_step(1, 1, 0, 0, 1'b0, 2);
        push_step(1, 2, 0, 0, 1'b0, 2);
        push_idle(1'b1, 1'b0, 1'b0, 1);
        push_idle(1'b0, 1'b0, 1'b0, 4);
        clk_div = DW'(1);
        set_frame(4, 1, 1, 1, 1, 1'b0);
        integration = 1'b1;
        wait_sig(col(1, 2), 50);
        @(posedge clk);
        #1;
        reset = 1'b1;
        integration = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(negedge clk);

        nchk++;
        if (expq.size() == 0)
            npass++;
        else
            $display("FAIL pending events: %0d expected events never seen, required 0", expq.size());

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
